regfile_writeback: RTL

Write-side front end for the 32×32 register file. It collects destination writes from the single-cycle ALU path and the multi-cycle multiply/divide path and queues them in program order. It drains them one per cycle onto the register file's single write port (ctrl_writeEnable / ctrl_writeReg / data_writeReg). It also exposes a pending-register scoreboard and a forwarding lookup so decode can stall on, or bypass, writes not yet committed.

---
 rtl/regfile_writeback.sv | 127 ++++++++++++
 1 files changed

// File: rtl/regfile_writeback.sv
// Write-side front end for the register file: merges ALU and multdiv results into an
// in-order FIFO drained one per cycle, with a pending scoreboard and a forwarding lookup.
module regfile_writeback #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clock,
  input  logic        ctrl_reset,
  input  logic        md_valid,
  input  logic [4:0]  md_rd,
  input  logic [31:0] md_data,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        in_ready,
  output logic        ctrl_writeEnable,
  output logic [4:0]  ctrl_writeReg,
  output logic [31:0] data_writeReg,
  output logic [31:0] pending,
  input  logic [4:0]  query_reg,
  output logic        query_hit,
  output logic [31:0] query_data,
  output logic        idle,
  output logic        overflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [4:0]       rd_q   [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;

  logic          pop, md_req, alu_req, md_acc, alu_acc, drop;
  logic [CW-1:0] free_slots;
  logic [PW-1:0] alu_slot;

  // Slots available this edge count the entry being popped; md is older so it claims first.
  always_comb begin
    pop        = (count != '0);
    md_req     = md_valid && (md_rd != 5'd0);
    alu_req    = alu_valid && (alu_rd != 5'd0);
    free_slots = CW'(DEPTH) - count + CW'(pop);
    md_acc     = md_req && (free_slots != '0);
    alu_acc    = alu_req && (free_slots > CW'(md_acc));
    drop       = (md_req && !md_acc) || (alu_req && !alu_acc);
    alu_slot   = wr_ptr + PW'(md_acc);
  end

  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      count            <= '0;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      vld              <= '0;
      ctrl_writeEnable <= 1'b0;
      ctrl_writeReg    <= '0;
      data_writeReg    <= '0;
      overflow         <= 1'b0;
    end else begin
      if (pop) begin
        ctrl_writeEnable <= 1'b1;
        ctrl_writeReg    <= rd_q[rd_ptr];
        data_writeReg    <= data_q[rd_ptr];
        vld[rd_ptr]      <= 1'b0;
        rd_ptr           <= rd_ptr + PW'(1);
      end else begin
        ctrl_writeEnable <= 1'b0;
      end
      // A push into the slot freed by this edge's pop must win, so it comes after.
      if (md_acc)  vld[wr_ptr]   <= 1'b1;
      if (alu_acc) vld[alu_slot] <= 1'b1;
      wr_ptr <= wr_ptr + PW'(md_acc) + PW'(alu_acc);
      count  <= count + CW'(md_acc) + CW'(alu_acc) - CW'(pop);
      if (drop) overflow <= 1'b1;
    end
  end

  // Payload storage needs no reset; validity is tracked by vld and count.
  always_ff @(posedge clock) begin
    if (md_acc) begin
      rd_q[wr_ptr]   <= md_rd;
      data_q[wr_ptr] <= md_data;
    end
    if (alu_acc) begin
      rd_q[alu_slot]   <= alu_rd;
      data_q[alu_slot] <= alu_data;
    end
  end

  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i]) pending[rd_q[i]] = 1'b1;
    end
    if (ctrl_writeEnable) pending[ctrl_writeReg] = 1'b1;
    pending[0] = 1'b0;
  end

  // Walk output stage then head->tail so the youngest match is the one left standing.
  always_comb begin
    logic [PW-1:0] idx;
    idx        = '0;
    query_hit  = 1'b0;
    query_data = '0;
    if (ctrl_writeEnable && (ctrl_writeReg == query_reg)) begin
      query_hit  = 1'b1;
      query_data = data_writeReg;
    end
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if ((CW'(i) < count) && (rd_q[idx] == query_reg)) begin
        query_hit  = 1'b1;
        query_data = data_q[idx];
      end
    end
    if (query_reg == 5'd0) begin
      query_hit  = 1'b0;
      query_data = '0;
    end
  end

  assign in_ready = (CW'(DEPTH) - count) >= CW'(2);
  assign idle     = (count == '0) && !ctrl_writeEnable;

endmodule
